// File: rtl/em_pick_drop_seq_if.sv
// Command handshake between the motion/path controller and the gripper
// electromagnet sequencer.
interface em_pick_drop_seq_if;
    logic cmd_valid;  // command present
    logic cmd_op;     // 0 = PICK, 1 = DROP
    logic cmd_ready;  // sequencer can accept a command this cycle

    // Controller side: offers commands, observes readiness.
    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready
    );

    // Sequencer side: consumes commands, advertises readiness.
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready
    );
endinterface

// File: rtl/em_pick_drop_seq.sv
// Gripper electromagnet pick/drop sequencer.
// PICK energises the coil and reports grip after a settle time; DROP drives
// a short reverse demagnetise pulse, then waits a release time before
// reporting empty. Redundant commands pulse err; abort cancels a pick in
// progress by running the drop sequence. All outputs are registered.
module em_pick_drop_seq #(
    parameter int unsigned SETTLE_CYC  = 50000,
    parameter int unsigned DEMAG_CYC   = 5000,
    parameter int unsigned RELEASE_CYC = 25000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    em_pick_drop_seq_if.slave        cmd,
    input  logic                     i_abort,
    output logic [1:0]               o_em_out,
    output logic                     o_holding,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int unsigned MAX_A   = (SETTLE_CYC > DEMAG_CYC) ? SETTLE_CYC : DEMAG_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > RELEASE_CYC) ? MAX_A : RELEASE_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    // Counter reload values: each timed state counts down to zero, so a load
    // of N-1 gives a state lasting exactly N cycles.
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DEMAG_LD   = CNT_W'(DEMAG_CYC - 1);
    localparam logic [CNT_W-1:0] RELEASE_LD = CNT_W'(RELEASE_CYC - 1);

    localparam logic OP_PICK = 1'b0;
    localparam logic OP_DROP = 1'b1;

    localparam logic [1:0] EM_OFF     = 2'b00;
    localparam logic [1:0] EM_ATTRACT = 2'b01;
    localparam logic [1:0] EM_REVERSE = 2'b10;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_ENGAGE,
        ST_HOLDING,
        ST_DEMAG,
        ST_RELEASE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd_ready;
    logic [1:0]       r_em_out;
    logic             r_holding;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    wire w_accept   = cmd.cmd_valid & r_cmd_ready;
    wire w_cnt_zero = (r_cnt == '0);

    // Sequencer FSM: state, counter and every output are updated together
    // so outputs always reflect the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_em_out    <= EM_OFF;
            r_holding   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so later statements
            // in this block see the pre-edge values of every register.
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        if (cmd.cmd_op == OP_PICK) begin
                            r_state     <= ST_ENGAGE;
                            r_cnt       <= SETTLE_LD;
                            r_em_out    <= EM_ATTRACT;
                            r_busy      <= 1'b1;
                            r_cmd_ready <= 1'b0;
                        end else begin
                            r_err <= 1'b1;  // DROP with nothing held
                        end
                    end
                end
                ST_ENGAGE: begin
                    // Abort outranks settle expiry: the part may be half
                    // gripped, so it always gets a full demagnetise/release.
                    if (i_abort) begin
                        r_state  <= ST_DEMAG;
                        r_cnt    <= DEMAG_LD;
                        r_em_out <= EM_REVERSE;
                    end else if (w_cnt_zero) begin
                        r_state     <= ST_HOLDING;
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_holding   <= 1'b1;
                        r_done      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_HOLDING: begin
                    if (w_accept) begin
                        if (cmd.cmd_op == OP_DROP) begin
                            r_state     <= ST_DEMAG;
                            r_cnt       <= DEMAG_LD;
                            r_em_out    <= EM_REVERSE;
                            r_busy      <= 1'b1;
                            r_holding   <= 1'b0;
                            r_cmd_ready <= 1'b0;
                        end else begin
                            r_err <= 1'b1;  // PICK while already holding
                        end
                    end
                end
                ST_DEMAG: begin
                    if (w_cnt_zero) begin
                        r_state  <= ST_RELEASE;
                        r_cnt    <= RELEASE_LD;
                        r_em_out <= EM_OFF;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (w_cnt_zero) begin
                        r_state     <= ST_EMPTY;
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    // Unreachable encodings recover to a safe, coil-off idle.
                    r_state     <= ST_EMPTY;
                    r_cnt       <= '0;
                    r_cmd_ready <= 1'b1;
                    r_em_out    <= EM_OFF;
                    r_holding   <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = r_cmd_ready;
    assign o_em_out      = r_em_out;
    assign o_holding     = r_holding;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;

endmodule

// File: doc/em_pick_drop_seq.md
Name: em_pick_drop_seq

Overview:
- Sequences the gripper electromagnet for pick and drop operations, driving the 2-bit coil lines directly.
- Commands arrive from the motion/path controller over a valid/ready handshake.
- Pick: energise the magnet and wait a settle time before reporting grip.
- Drop: apply a short reverse demagnetise pulse, then wait a release time before reporting empty.
- Also handles redundant commands and aborted picks.

Parameters:
- SETTLE_CYC, 50000, cycles the coil is held energised after a pick before the grip is reported (minimum 1).
- DEMAG_CYC, 5000, cycles of reverse drive (em_out = 2'b10) at the start of a drop (minimum 1).
- RELEASE_CYC, 25000, cycles of coil-off wait after demagnetise before empty is reported (minimum 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_op  input  1  0 = PICK, 1 = DROP.
- cmd_ready  output  1  block can accept a command this cycle.
- abort  input  1  cancel an in-progress pick.
- em_out  output  2  coil drive: 01 = attract, 10 = reverse/demag, 00 = off; 11 is never driven.
- holding  output  1  object gripped (high only in HOLDING).
- busy  output  1  high in ENGAGE, DEMAG and RELEASE.
- done  output  1  one-cycle pulse on completion of a pick or drop.
- err  output  1  one-cycle pulse when a redundant command is accepted.

Behaviour:
- All outputs are registered. On reset (asynchronous, any state, mid-operation included):
  - state = EMPTY, em_out = 00, holding = 0, busy = 0, done = 0, err = 0, counter = 0.
  - cmd_ready = 1 in the first cycle after rst_n deasserts.
- States and coil drive:
  - EMPTY: em 00.
  - ENGAGE: em 01.
  - HOLDING: em 01.
  - DEMAG: em 10.
  - RELEASE: em 00.
- cmd_ready = 1 only in EMPTY and HOLDING. A command is accepted on a rising edge with cmd_valid & cmd_ready. cmd_op is sampled only at acceptance.
- EMPTY transitions:
  - Accept PICK: go to ENGAGE; em_out = 01 from the next cycle.
  - Accept DROP: redundant; err pulses for 1 cycle; stay in EMPTY; em unchanged.
- ENGAGE:
  - Lasts exactly SETTLE_CYC cycles, then goes to HOLDING.
  - done = 1 during the first HOLDING cycle.
- HOLDING transitions:
  - Accept DROP: go to DEMAG.
  - Accept PICK: redundant; err pulses; stay in HOLDING.
- DEMAG: lasts exactly DEMAG_CYC cycles, then goes to RELEASE.
- RELEASE:
  - Lasts exactly RELEASE_CYC cycles, then goes to EMPTY.
  - done = 1 during the first EMPTY cycle.
- abort:
  - In ENGAGE: takes priority over counter expiry. Next state is DEMAG, the counter restarts, and no done is produced for the pick. The drop sequence then completes normally and does produce done on entry to EMPTY.
  - In all other states: ignored.
- em_out never transitions directly between 01 and 10 except HOLDING→DEMAG and ENGAGE→DEMAG (intended reverse pulse). em_out = 11 must be unreachable.
- Counter:
  - Single down- or up-counter sized to $clog2 of the largest parameter + 1.
  - Reloads on every state entry; no wrap-around is possible.
- done and err are never high in the same cycle. Each is high for exactly one cycle per event.
- Latency from accepted PICK to done: SETTLE_CYC + 1 cycles.
- Latency from accepted DROP to done: DEMAG_CYC + RELEASE_CYC + 1 cycles.

Test Plan:
- All tests use SETTLE_CYC=4, DEMAG_CYC=2, RELEASE_CYC=3.
- Reset: assert rst_n=0 mid-ENGAGE -> em_out=00, busy=0, holding=0 immediately (asynchronous); cmd_ready=1 after release.
- Pick: PICK accepted at edge 0 -> em_out=01 and busy=1 for 4 cycles; holding=1 and done=1 at cycle 5; done low at cycle 6; cmd_ready=1.
- Drop: from HOLDING, DROP accepted -> em_out=10 for 2 cycles, then 00 for 3 cycles (busy=1 throughout); done=1 with holding=0 in the 6th cycle.
- Redundant: DROP in EMPTY -> err=1 for one cycle, em_out stays 00. PICK in HOLDING -> err=1, em_out stays 01, holding stays 1.
- Abort: abort=1 in the 2nd ENGAGE cycle -> em_out=10 next cycle for 2 cycles, then 00 for 3 cycles; single done on entry to EMPTY; never holding=1.
- Handshake: cmd_valid held high during busy -> no acceptance until cmd_ready=1. Back-to-back PICK then DROP with cmd_valid always high -> DROP accepted in the first HOLDING cycle. Assert em_out != 11 throughout all tests.
